pingpong_ctrl: RTL



---
 rtl/pingpong_ctrl_if.sv | 43 ++++
 rtl/pingpong_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pingpong_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_ctrl_if
// Purpose  : Sample-in, buffer-port, and stream-out signals of the ping-pong
//            sequencer, bundled for the controller and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface pingpong_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 9
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          wren;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_q;
    logic          swap;
    logic          bank;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          overflow;
    logic          overflow_clr;
    logic [15:0]   drop_count;

    // Controller side
    modport master (
        input  in_valid, in_data, r_q, out_ready, overflow_clr,
        output w_addr, w_data, wren, r_addr, swap, bank,
               out_valid, out_data, out_last, overflow, drop_count
    );

    // Environment side: sample source, buffer RAM and stream consumer
    modport slave (
        output in_valid, in_data, r_q, out_ready, overflow_clr,
        input  w_addr, w_data, wren, r_addr, swap, bank,
               out_valid, out_data, out_last, overflow, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_ctrl
// Purpose  : Sequencer for a two-bank ping-pong sample buffer. Fills the write
//            bank from a sample strobe, pulses swap when the bank is full and
//            the previous bank has been drained, then streams the completed
//            bank to a valid/ready consumer around the 1-cycle RAM latency.
//            Samples arriving with no room are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 9,
    parameter int DEPTH = 512   // must equal 2**AW
) (
    input  wire             clk,
    input  wire             reset,
    pingpong_ctrl_if.master bus
);

    localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_wc_one    = (AW+1)'(1);
    localparam logic [AW-1:0] c_ra_one    = AW'(1);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_LAT  = 2'd1;
    localparam logic [1:0] R_OUT  = 2'd2;

    logic [AW:0]   r_wcount;
    logic          r_swap;
    logic          r_bank;
    logic          r_rd_pending;
    logic [1:0]    r_state;
    logic [AW-1:0] r_raddr;
    logic          r_overflow;
    logic [15:0]   r_drop_count;

    logic          w_full;
    logic          w_accept;
    logic          w_drop;
    logic          w_swap_set;
    logic          w_rd_start;
    logic          w_rd_advance;
    logic [1:0]    w_state_nxt;
    logic          w_out_valid;
    logic          w_out_last;

    // The swap-high cycle already sees wcount==0, so it must block writes itself.
    assign w_full     = (r_wcount == c_depth);
    assign w_accept   = bus.in_valid && !w_full && !r_swap;
    assign w_drop     = bus.in_valid && (w_full || r_swap);
    // Swap only once the reader has fully released the other bank.
    assign w_swap_set = w_full && (r_state == R_IDLE) && !r_rd_pending;

    assign w_rd_start   = (r_state == R_IDLE) && r_rd_pending;
    assign w_rd_advance = (r_state == R_OUT) && bus.out_ready && !w_out_last;

    assign bus.wren       = w_accept;
    assign bus.w_addr     = r_wcount[AW-1:0];
    assign bus.w_data     = bus.in_data;
    assign bus.r_addr     = r_raddr;
    assign bus.swap       = r_swap;
    assign bus.bank       = r_bank;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = bus.r_q;
    assign bus.out_last   = w_out_last;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop_count;

    // Write fill level, swap pulse, bank mirror and read hand-off flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcount     <= '0;
            r_swap       <= 1'b0;
            r_bank       <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_swap <= w_swap_set;
            if (w_swap_set) begin
                r_wcount <= '0;
                r_bank   <= ~r_bank;
            end else if (w_accept) begin
                r_wcount <= r_wcount + c_wc_one;
            end
            if (w_swap_set) begin
                r_rd_pending <= 1'b1;
            end else if (w_rd_start) begin
                r_rd_pending <= 1'b0;
            end
        end
    end

    // Overrun bookkeeping; a clear in the same cycle as a drop wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (bus.overflow_clr) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Read engine state and address; address only moves between presented samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_raddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_start) begin
                r_raddr <= '0;
            end else if (w_rd_advance) begin
                r_raddr <= r_raddr + c_ra_one;
            end
        end
    end

    // Read engine next state and stream outputs
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (r_rd_pending) begin
                    w_state_nxt = R_LAT;
                end
            end
            R_LAT: begin
                w_state_nxt = R_OUT;
            end
            R_OUT: begin
                w_out_valid = 1'b1;
                w_out_last  = (r_raddr == c_last_addr);
                if (bus.out_ready) begin
                    w_state_nxt = w_out_last ? R_IDLE : R_LAT;
                end
            end
            default: begin
                w_state_nxt = R_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
